// File: rtl/tick_counter_3b.sv
// rtl/tick_counter_3b.sv - prescaled 3-bit up/down digit counter with run/pause control
// Feeds the seven-segment decoder's data_i; tick/wrap strobe with each counted value.
module tick_counter_3b #(
  parameter int DIV_RATIO = 4,
  parameter int MAX_VAL   = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       up_i,
  output logic [2:0] data_o,
  output logic       tick_o,
  output logic       wrap_o,
  output logic       running_o
);

  localparam int              DW       = $clog2(DIV_RATIO);
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV_RATIO - 1);
  localparam logic [2:0]      MAX_V    = 3'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [2:0]    data_n;
  logic          tick_n, wrap_n;
  logic [2:0]    step_val;
  logic          step_wrap;
  logic [2:0]    load_clamped;

  // Value and wrap flag the counter would take on a tick edge
  always_comb begin
    step_val  = data_o;
    step_wrap = 1'b0;
    if (up_i) begin
      if (data_o >= MAX_V) begin
        step_val  = 3'd0;
        step_wrap = 1'b1;
      end else begin
        step_val = data_o + 3'd1;
      end
    end else begin
      if (data_o == 3'd0 || data_o > MAX_V) begin
        step_val  = MAX_V;
        step_wrap = 1'b1;
      end else begin
        step_val = data_o - 3'd1;
      end
    end
  end

  assign load_clamped = (load_val_i > MAX_V) ? MAX_V : load_val_i;

  // Control priority: clear > load > stop > start > count
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    data_n  = data_o;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    if (clear_i) begin
      state_n = IDLE;
      div_n   = '0;
      data_n  = 3'd0;
    end else if (load_i) begin
      div_n  = '0;
      data_n = load_clamped;
    end else if (stop_i) begin
      if (state == RUN) begin
        state_n = PAUSE;
      end
    end else if (start_i && state != RUN) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (div_cnt == DIV_LAST) begin
        div_n  = '0;
        data_n = step_val;
        tick_n = 1'b1;
        wrap_n = step_wrap;
      end else begin
        div_n = div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      div_cnt   <= '0;
      data_o    <= 3'd0;
      tick_o    <= 1'b0;
      wrap_o    <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      data_o    <= data_n;
      tick_o    <= tick_n;
      wrap_o    <= wrap_n;
      running_o <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_tick_counter_3b.sv
// tb/tb_tick_counter_3b.sv - scoreboard bench for tick_counter_3b
module tb_tick_counter_3b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, load_i = 1'b0, up_i = 1'b1;
  logic [2:0] load_val_i = 3'd0;
  logic [2:0] data_o;
  logic       tick_o, wrap_o, running_o;

  logic       start2 = 1'b0, load2 = 1'b0;
  logic [2:0] load_val2 = 3'd0;
  logic [2:0] data2;
  logic       tick2, wrap2, running2;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    int         c;
    logic [2:0] d;
    logic       w;
  } exp_t;
  exp_t q[$];

  tick_counter_3b #(.DIV_RATIO(4), .MAX_VAL(7)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .load_i(load_i), .load_val_i(load_val_i), .up_i(up_i),
    .data_o(data_o), .tick_o(tick_o), .wrap_o(wrap_o), .running_o(running_o)
  );

  tick_counter_3b #(.DIV_RATIO(4), .MAX_VAL(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .stop_i(1'b0), .clear_i(1'b0),
    .load_i(load2), .load_val_i(load_val2), .up_i(1'b1),
    .data_o(data2), .tick_o(tick2), .wrap_o(wrap2), .running_o(running2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] d, input logic w);
    exp_t e;
    e.c = c; e.d = d; e.w = w;
    q.push_back(e);
  endtask

  // Every strobe must match the oldest expected tick
  always @(negedge clk) begin
    if (!rst && (tick_o || wrap_o)) begin
      if (q.size() == 0) begin
        chk("unexpected_tick_cycle", cyc, -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_cycle", cyc, e.c);
        chk("tick_data", int'(data_o), int'(e.d));
        chk("tick_wrap", int'(wrap_o), int'(e.w));
        chk("tick_strobe", int'(tick_o), 1);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    s = cyc + 1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    int s, r;
    @(negedge clk);
    chk("rst_data", int'(data_o), 0);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_wrap", int'(wrap_o), 0);
    chk("rst_running", int'(running_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // up count through a full wrap
    up_i = 1'b1;
    pulse_start(s);
    for (int k = 1; k <= 8; k++) push(s + 4*k, 3'(k % 8), k == 8);
    wait_until(s + 20);
    chk("t1_running", int'(running_o), 1);
    wait_until(s + 33);
    chk("t1_pending", q.size(), 0);
    do_clear();
    chk("t1_clear_running", int'(running_o), 0);

    // down count wraps 0 -> 7 first
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    up_i = 1'b0;
    pulse_start(s);
    push(s + 4, 3'd7, 1'b1);
    push(s + 8, 3'd6, 1'b0);
    wait_until(s + 9);
    chk("t2_pending", q.size(), 0);
    do_clear();
    up_i = 1'b1;

    // pause holds data and prescaler phase
    pulse_start(s);
    push(s + 4, 3'd1, 1'b0);
    wait_until(s + 6);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t3_stop_running", int'(running_o), 0);
    repeat (10) @(negedge clk);
    chk("t3_hold_data", int'(data_o), 1);
    chk("t3_hold_running", int'(running_o), 0);
    pulse_start(r);
    push(r + 2, 3'd2, 1'b0);
    wait_until(r + 3);
    chk("t3_pending", q.size(), 0);
    chk("t3_resume_running", int'(running_o), 1);
    do_clear();

    // load mid-run, then load on a would-be tick edge
    pulse_start(s);
    wait_until(s + 1);
    load_i = 1'b1; load_val_i = 3'd5;
    @(negedge clk);
    load_i = 1'b0;
    chk("t4_load_data", int'(data_o), 5);
    chk("t4_load_tick", int'(tick_o), 0);
    push(s + 6, 3'd6, 1'b0);
    wait_until(s + 9);
    load_i = 1'b1; load_val_i = 3'd2;
    @(negedge clk);
    load_i = 1'b0;
    chk("t4_tickedge_load_data", int'(data_o), 2);
    push(s + 14, 3'd3, 1'b0);
    wait_until(s + 15);
    chk("t4_pending", q.size(), 0);
    do_clear();

    // load clamp and wrap at MAX_VAL=5
    load2 = 1'b1; load_val2 = 3'd7;
    @(negedge clk);
    load2 = 1'b0;
    chk("t4_clamp_data", int'(data2), 5);
    s = cyc + 1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_until(s + 4);
    chk("t4_max5_tick", int'(tick2), 1);
    chk("t4_max5_data", int'(data2), 0);
    chk("t4_max5_wrap", int'(wrap2), 1);

    // clear wins over load and start
    pulse_start(s);
    push(s + 4, 3'd1, 1'b0);
    wait_until(s + 5);
    clear_i = 1'b1; load_i = 1'b1; load_val_i = 3'd6; start_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; load_i = 1'b0; start_i = 1'b0;
    chk("t5_data", int'(data_o), 0);
    chk("t5_running", int'(running_o), 0);
    repeat (8) @(negedge clk);
    chk("t5_idle_data", int'(data_o), 0);
    chk("t5_idle_running", int'(running_o), 0);
    chk("t5_pending", q.size(), 0);

    // asynchronous reset mid-run
    pulse_start(s);
    push(s + 4, 3'd1, 1'b0);
    push(s + 8, 3'd2, 1'b0);
    push(s + 12, 3'd3, 1'b0);
    wait_until(s + 13);
    chk("t6_pre_data", int'(data_o), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_data", int'(data_o), 0);
    chk("t6_async_tick", int'(tick_o), 0);
    chk("t6_async_wrap", int'(wrap_o), 0);
    chk("t6_async_running", int'(running_o), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_pending", q.size(), 0);
    repeat (8) @(negedge clk);
    chk("t6_idle_data", int'(data_o), 0);
    chk("t6_idle_running", int'(running_o), 0);
    pulse_start(s);
    push(s + 4, 3'd1, 1'b0);
    wait_until(s + 5);
    chk("t6_restart_pending", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
